sample_sequencer: RTL and testbench

Drives a combinational constraint checker (one-bit "all constraints satisfied" result) with pseudo-random candidate assignment vectors. It repeats until a requested number of satisfying samples has been handed to a downstream consumer, or an attempt budget runs out. The checker sits outside the block: it receives cand_out and returns sat_in in the same cycle. This block is the rejection-sampling controller around the generated checker modules.

---
 rtl/sample_sequencer.sv | 154 +++++++++++++++
 tb/tb_sample_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_sequencer.sv
// Rejection-sampling controller: feeds LFSR-generated candidates to an external
// constraint checker and hands satisfying vectors to a downstream consumer.
module sample_sequencer #(
  parameter int CAND_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       seed,
  input  logic              seed_load,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  num_samples,
  input  logic [CNT_W-1:0]  max_attempts,
  output logic [CAND_W-1:0] cand_out,
  input  logic              sat_in,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic [CAND_W-1:0] sample_data,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [CNT_W-1:0]  attempt_count,
  output logic [CNT_W-1:0]  accept_count
);

  localparam int WORDS = CAND_W / 32;
  localparam int WI_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [WI_W-1:0] LAST_WORD = WI_W'(WORDS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_GEN   = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]         state;
  logic [31:0]        lfsr;
  logic [31:0]        lfsr_next;
  logic [WI_W-1:0]    word_idx;
  logic [CNT_W-1:0]   num_lat;
  logic [CNT_W-1:0]   max_lat;
  logic [CNT_W-1:0]   attempt_inc;
  logic [CNT_W-1:0]   accept_inc;
  logic [CAND_W+31:0] cand_cat;
  logic [CAND_W-1:0]  cand_shift;

  always_comb begin
    lfsr_next   = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? 32'h8020_0003 : 32'h0);
    attempt_inc = (&attempt_count) ? attempt_count : attempt_count + 1'b1;
    accept_inc  = (&accept_count) ? accept_count : accept_count + 1'b1;
    // Low CAND_W bits of the concatenation give the shift-in also for CAND_W==32
    cand_cat    = {cand_out, lfsr};
    cand_shift  = cand_cat[CAND_W-1:0];
  end

  assign done = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      lfsr          <= 32'h1;
      word_idx      <= '0;
      num_lat       <= '0;
      max_lat       <= '0;
      cand_out      <= '0;
      sample_data   <= '0;
      sample_valid  <= 1'b0;
      busy          <= 1'b0;
      fail          <= 1'b0;
      attempt_count <= '0;
      accept_count  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (seed_load) lfsr <= (seed == 32'h0) ? 32'h1 : seed;
          if (start) begin
            num_lat       <= num_samples;
            max_lat       <= max_attempts;
            attempt_count <= '0;
            accept_count  <= '0;
            fail          <= 1'b0;
            word_idx      <= '0;
            if (num_samples == '0) begin
              state <= S_DONE;
            end else begin
              busy  <= 1'b1;
              state <= S_GEN;
            end
          end
        end
        S_GEN: begin
          if (abort) begin
            fail  <= 1'b1;
            state <= S_DONE;
          end else begin
            cand_out <= cand_shift;
            lfsr     <= lfsr_next;
            if (word_idx == LAST_WORD) begin
              word_idx <= '0;
              state    <= S_CHECK;
            end else begin
              word_idx <= word_idx + 1'b1;
            end
          end
        end
        S_CHECK: begin
          if (abort) begin
            fail  <= 1'b1;
            state <= S_DONE;
          end else begin
            attempt_count <= attempt_inc;
            if (sat_in) begin
              sample_data  <= cand_out;
              sample_valid <= 1'b1;
              state        <= S_HOLD;
            end else if (max_lat != '0 && attempt_inc == max_lat) begin
              fail  <= 1'b1;
              state <= S_DONE;
            end else begin
              state <= S_GEN;
            end
          end
        end
        S_HOLD: begin
          if (abort) begin
            sample_valid <= 1'b0;
            fail         <= 1'b1;
            state        <= S_DONE;
          end else if (sample_valid && sample_ready) begin
            sample_valid <= 1'b0;
            accept_count <= accept_inc;
            // Delivery first: a budget-exhausting hit still reaches the consumer
            if (accept_inc == num_lat) begin
              state <= S_DONE;
            end else if (max_lat != '0 && attempt_count == max_lat) begin
              fail  <= 1'b1;
              state <= S_DONE;
            end else begin
              state <= S_GEN;
            end
          end
        end
        S_DONE: begin
          busy     <= 1'b0;
          word_idx <= '0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sample_sequencer.sv
// Bench for sample_sequencer: table of complete runs with a sample scoreboard,
// plus directed sequences for stalls, abort, and asynchronous reset.
module tb_sample_sequencer;

  localparam int CAND_W = 64;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [31:0]       seed;
  logic              seed_load;
  logic              start;
  logic              abort;
  logic [CNT_W-1:0]  num_samples;
  logic [CNT_W-1:0]  max_attempts;
  logic [CAND_W-1:0] cand_out;
  logic              sat_in;
  logic              sample_valid;
  logic              sample_ready;
  logic [CAND_W-1:0] sample_data;
  logic              busy;
  logic              done;
  logic              fail;
  logic [CNT_W-1:0]  attempt_count;
  logic [CNT_W-1:0]  accept_count;

  sample_sequencer #(.CAND_W(CAND_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .seed(seed), .seed_load(seed_load),
    .start(start), .abort(abort), .num_samples(num_samples),
    .max_attempts(max_attempts), .cand_out(cand_out), .sat_in(sat_in),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .sample_data(sample_data), .busy(busy), .done(done), .fail(fail),
    .attempt_count(attempt_count), .accept_count(accept_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] seed;
    int          num;
    int          max;
    logic        sat;
    int          exp_att;
    int          exp_acc;
    logic        exp_fail;
    int          done_cyc;
  } vec_t;

  vec_t              vecs [7];
  logic [CAND_W-1:0] exp_q [$];
  int                checks = 0;
  int                errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lnext(input logic [31:0] l);
    return (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  // Every candidate is accepted when sat_in is tied high, so the n-th sample is
  // the n-th pair of LFSR words, first word in the upper half.
  task automatic push_samples(input logic [31:0] s, input int n);
    logic [31:0] l;
    logic [31:0] w0;
    l = (s == 32'h0) ? 32'h1 : s;
    for (int k = 0; k < n; k++) begin
      w0 = l;
      l  = lnext(l);
      exp_q.push_back({w0, l});
      l  = lnext(l);
    end
  endtask

  task automatic kick(input logic [31:0] s, input int n, input int mx, input logic sat, input logic rdy);
    @(negedge clk);
    seed = s; seed_load = 1'b1; start = 1'b1;
    num_samples = CNT_W'(n); max_attempts = CNT_W'(mx);
    sat_in = sat; sample_ready = rdy;
    @(negedge clk);
    seed_load = 1'b0; start = 1'b0;
  endtask

  task automatic pop_chk(input string name);
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s actual=unexpected_sample required=none", name);
    end else begin
      chk(name, sample_data, exp_q.pop_front());
    end
  endtask

  task automatic run_vec(input vec_t v);
    int c = 1;
    int first_valid = -1;
    bit seen = 0;
    exp_q.delete();
    push_samples(v.seed, v.exp_acc);
    kick(v.seed, v.num, v.max, v.sat, 1'b1);
    while (c < 300 && !seen) begin
      if (sample_valid && first_valid < 0) first_valid = c;
      if (sample_valid && sample_ready) pop_chk("sample_data");
      if (done) begin
        seen = 1;
        chk("done_cycle", c, v.done_cyc);
        chk("attempt_count", attempt_count, v.exp_att);
        chk("accept_count", accept_count, v.exp_acc);
        chk("fail", fail, v.exp_fail);
      end else begin
        @(negedge clk);
        c++;
      end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL run_timeout actual=no_done required=done");
    end
    chk("samples_left", exp_q.size(), 0);
    chk("first_valid_cycle", first_valid, (v.exp_acc > 0) ? 4 : -1);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("busy_after_done", busy, 0);
  endtask

  task automatic wait_valid(input string name);
    int c = 0;
    while (!sample_valid && c < 50) begin
      @(negedge clk);
      c++;
    end
    if (!sample_valid) begin
      checks++; errors++;
      $display("FAIL %s actual=no_valid required=valid", name);
    end
  endtask

  task automatic wait_done(input string name);
    int c = 0;
    while (!done && c < 100) begin
      @(negedge clk);
      c++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s actual=no_done required=done", name);
    end
  endtask

  initial begin
    logic [CAND_W-1:0] held;
    //          seed          num max sat att acc fail done
    vecs[0] = '{32'h0000_0001, 3, 0, 1'b1, 3, 3, 1'b0, 13};
    vecs[1] = '{32'h0000_0001, 2, 5, 1'b0, 5, 0, 1'b1, 16};
    vecs[2] = '{32'h0000_0000, 3, 0, 1'b1, 3, 3, 1'b0, 13};
    vecs[3] = '{32'hDEAD_BEEF, 4, 4, 1'b1, 4, 4, 1'b0, 17};
    vecs[4] = '{32'h0000_0005, 3, 2, 1'b1, 2, 2, 1'b1, 9};
    vecs[5] = '{32'h1234_5678, 0, 0, 1'b1, 0, 0, 1'b0, 1};
    vecs[6] = '{32'hCAFE_0001, 1, 1, 1'b0, 1, 0, 1'b1, 4};

    rst_n = 1'b0; seed = '0; seed_load = 1'b0; start = 1'b0; abort = 1'b0;
    num_samples = '0; max_attempts = '0; sat_in = 1'b0; sample_ready = 1'b0;
    #1;
    chk("reset_cand_out", cand_out, 0);
    chk("reset_flags", {sample_valid, busy, done, fail}, 0);
    chk("reset_counts", {attempt_count, accept_count}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Consumer stall: sample held stable, LFSR frozen while holding
    exp_q.delete();
    push_samples(32'h1, 2);
    kick(32'h1, 2, 0, 1'b1, 1'b0);
    wait_valid("hold_first_valid");
    held = sample_data;
    pop_chk("hold_first_data");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_valid", sample_valid, 1);
      chk("hold_data", sample_data, held);
    end
    sample_ready = 1'b1;
    @(negedge clk);
    chk("hold_released_valid", sample_valid, 0);
    chk("hold_accept_one", accept_count, 1);
    wait_valid("hold_second_valid");
    pop_chk("hold_second_data");
    wait_done("hold_done");
    chk("hold_attempts", attempt_count, 2);
    chk("hold_accepts", accept_count, 2);
    @(negedge clk);

    // Abort while a sample is pending
    kick(32'h7, 2, 0, 1'b1, 1'b0);
    wait_valid("abort_valid");
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_valid_dropped", sample_valid, 0);
    chk("abort_fail", fail, 1);
    chk("abort_done", done, 1);
    chk("abort_accept", accept_count, 0);
    @(negedge clk);
    chk("abort_busy", busy, 0);
    kick(32'h9, 1, 0, 1'b1, 1'b1);
    chk("restart_fail_clear", fail, 0);
    chk("restart_counts_clear", {attempt_count, accept_count}, 0);
    chk("restart_busy", busy, 1);
    wait_done("restart_done");
    @(negedge clk);

    // Asynchronous reset in the middle of GEN
    kick(32'h1, 3, 0, 1'b1, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_cand_out", cand_out, 0);
    chk("midreset_sample_data", sample_data, 0);
    chk("midreset_flags", {sample_valid, busy, done, fail}, 0);
    chk("midreset_counts", {attempt_count, accept_count}, 0);
    @(negedge clk);
    chk("midreset_no_done", done, 0);
    rst_n = 1'b1;
    run_vec(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
